// File: rtl/ct_spsram_pkg.sv
// Shared types and taint helper for the taint-shadowed single-port SRAM.
// Holds the init FSM encoding and the control-taint OR rule used on both write and read paths.
package ct_spsram_pkg;

  typedef enum logic [0:0] {
    SRAM_INIT = 1'b0,
    SRAM_DONE = 1'b1
  } sram_state_e;

  // Any taint on the control or address path contaminates every bit the access touches.
  function automatic logic ctrl_taint(input logic cen_t0, input logic gwen_t0, input logic addr_t0_any);
    return cen_t0 | gwen_t0 | addr_t0_any;
  endfunction

endpackage

// File: rtl/ct_spsram_bitmask_array.sv
// Row array with one masked write and one read per cycle, read data registered.
// Read data holds between reads and clears on reset; array contents are not reset.
module ct_spsram_bitmask_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 108
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;
  logic [DATA_WIDTH-1:0] rd_dat_d;
  logic [DATA_WIDTH-1:0] wr_row_d;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_vld) begin
      rd_dat_d = mem_q[rd_addr];
    end
    wr_row_d = (mem_q[wr_addr] & ~wr_mask) | (wr_dat & wr_mask);
  end

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem_q[wr_addr] <= wr_row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ct_spsram_shadow_param.sv
// Single-port SRAM with per-bit taint shadow, zero-filled after reset before accesses are honoured.
// Read latency 1 cycle; READY=0 during the DEPTH-cycle fill, user accesses ignored until then.
module ct_spsram_shadow_param
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 108,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  READY
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  ready_q, ready_d;
  logic                  force_q, force_d;

  logic                  init_wr;
  logic                  act, wr, rd, idle;
  logic                  ctrl_t;

  logic                  arr_wr_vld;
  logic [ADDR_WIDTH-1:0] arr_wr_addr;
  logic [DATA_WIDTH-1:0] dat_wr_mask, dat_wr_dat;
  logic [DATA_WIDTH-1:0] tnt_wr_mask, tnt_wr_dat;
  logic [DATA_WIDTH-1:0] dat_rd, tnt_rd;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      SRAM_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ROW) begin
          state_d = SRAM_DONE;
        end
      end
      SRAM_DONE: state_d = SRAM_DONE;
      default:   state_d = SRAM_INIT;
    endcase
    // READY tracks the state being entered so it rises on the edge that writes the last row.
    ready_d = (state_d == SRAM_DONE);
  end

  always_comb begin
    init_wr = (state_q == SRAM_INIT);
    act     = ready_q & ~CEN;
    wr      = act & ~GWEN;
    rd      = act & GWEN;
    idle    = ready_q & CEN;
    ctrl_t  = ctrl_taint(CEN_t0, GWEN_t0, |A_t0);

    arr_wr_vld  = init_wr | wr;
    arr_wr_addr = init_wr ? init_cnt_q : A;
    dat_wr_mask = init_wr ? '1 : ~WEN;
    dat_wr_dat  = init_wr ? '0 : D;
    // A tainted WEN bit may or may not have written, so its taint is set even when WEN=1.
    tnt_wr_mask = init_wr ? '1 : (~WEN | WEN_t0);
    tnt_wr_dat  = init_wr ? '0 : (D_t0 | WEN_t0 | {DATA_WIDTH{ctrl_t}});

    force_d = force_q;
    if (rd) begin
      force_d = ctrl_t;
    end else if (idle && CEN_t0) begin
      force_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT_EN ? SRAM_INIT : SRAM_DONE;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      force_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      force_q    <= force_d;
    end
  end

  ct_spsram_bitmask_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dat_array (
    .clk     (CLK),
    .rst     (RST),
    .wr_vld  (arr_wr_vld),
    .wr_addr (arr_wr_addr),
    .wr_mask (dat_wr_mask),
    .wr_dat  (dat_wr_dat),
    .rd_vld  (rd),
    .rd_addr (A),
    .rd_dat  (dat_rd)
  );

  ct_spsram_bitmask_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tnt_array (
    .clk     (CLK),
    .rst     (RST),
    .wr_vld  (arr_wr_vld),
    .wr_addr (arr_wr_addr),
    .wr_mask (tnt_wr_mask),
    .wr_dat  (tnt_wr_dat),
    .rd_vld  (rd),
    .rd_addr (A),
    .rd_dat  (tnt_rd)
  );

  assign Q     = dat_rd;
  assign Q_t0  = tnt_rd | {DATA_WIDTH{force_q}};
  assign READY = ready_q;

endmodule

// File: tb/tb_ct_spsram_shadow_param.sv
// Directed plus randomized bench for the taint-shadowed SRAM against a row-array reference model.
module tb_ct_spsram_shadow_param;

  localparam int AW    = 6;
  localparam int DW    = 108;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] ONES = '1;

  logic          CLK;
  logic          RST;
  logic [AW-1:0] A, A_t0;
  logic          CEN, CEN_t0, GWEN, GWEN_t0;
  logic [DW-1:0] WEN, WEN_t0, D, D_t0;
  logic [DW-1:0] Q, Q_t0;
  logic          READY;

  ct_spsram_shadow_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q), .Q_t0(Q_t0), .READY(READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_dat [DEPTH];
  logic [DW-1:0] m_tnt [DEPTH];
  logic [DW-1:0] exp_q, exp_qt;
  logic          exp_rdy;
  int            init_left;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // Reference behaviour: what the memory must look like after this clock edge.
  task automatic model_step();
    logic ct;
    int   row;
    if (RST) begin
      exp_q = '0; exp_qt = '0; exp_rdy = 1'b0; init_left = DEPTH;
    end else if (!exp_rdy) begin
      row = DEPTH - init_left;
      m_dat[row] = '0;
      m_tnt[row] = '0;
      init_left--;
      if (init_left == 0) exp_rdy = 1'b1;
    end else begin
      ct = (A_t0 != 0) || GWEN_t0 || CEN_t0;
      if (!CEN && !GWEN) begin
        for (int i = 0; i < DW; i++) begin
          if (!WEN[i]) begin
            m_dat[A][i] = D[i];
            m_tnt[A][i] = D_t0[i] | WEN_t0[i] | ct;
          end else if (WEN_t0[i]) begin
            m_tnt[A][i] = 1'b1;
          end
        end
      end else if (!CEN && GWEN) begin
        exp_q  = m_dat[A];
        exp_qt = ct ? ONES : m_tnt[A];
      end else if (CEN_t0) begin
        exp_qt = ONES;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    chk("q", Q, exp_q);
    chk("q_t0", Q_t0, exp_qt);
    chk("ready", {{(DW-1){1'b0}}, READY}, {{(DW-1){1'b0}}, exp_rdy});
  endtask

  task automatic clear_taint();
    A_t0 = '0; CEN_t0 = 1'b0; GWEN_t0 = 1'b0; WEN_t0 = '0; D_t0 = '0;
  endtask

  task automatic do_idle();
    CEN = 1'b1; GWEN = 1'b1; WEN = ONES;
    cyc();
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    CEN = 1'b0; GWEN = 1'b0; A = a; D = d; WEN = wen;
    cyc();
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    CEN = 1'b0; GWEN = 1'b1; A = a; WEN = ONES;
    cyc();
  endtask

  initial begin
    int n;
    RST = 1'b1; A = '0; D = '0; WEN = ONES; CEN = 1'b1; GWEN = 1'b1;
    clear_taint();
    exp_q = '0; exp_qt = '0; exp_rdy = 1'b0; init_left = DEPTH;

    cyc();
    cyc();
    chk("rst_ready", {{(DW-1){1'b0}}, READY}, '0);
    chk("rst_q", Q, '0);

    // Fill: READY must rise exactly 64 cycles after reset deasserts.
    RST = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 200) begin
      do_idle();
      n++;
    end
    chk("init_cycles", DW'(n), DW'(64));

    for (int r = 0; r < DEPTH; r++) begin
      do_rd(AW'(r));
      chk("init_row_q", Q, '0);
      chk("init_row_qt", Q_t0, '0);
    end

    D_t0 = DW'(8);
    do_wr(AW'(5), ONES, '0);
    clear_taint();
    do_rd(AW'(5));
    chk("a5_q", Q, ONES);
    chk("a5_qt", Q_t0, DW'(8));

    do_wr(AW'(7), ONES, '0);
    do_wr(AW'(7), '0, DW'(1));
    do_rd(AW'(7));
    chk("a7_q", Q, DW'(1));
    chk("a7_qt", Q_t0, '0);

    A_t0 = AW'(1);
    do_rd(AW'(9));
    chk("a9_qt", Q_t0, ONES);
    clear_taint();
    do_idle();
    chk("idle_hold_q", Q, '0);
    chk("idle_hold_qt", Q_t0, ONES);

    GWEN_t0 = 1'b1;
    do_wr(AW'(2), rnd_word(), '0);
    clear_taint();
    do_rd(AW'(2));
    chk("a2_qt", Q_t0, ONES);

    // Idle with tainted CEN forces Q_t0, a clean read then restores the row taint.
    CEN_t0 = 1'b1;
    do_idle();
    clear_taint();
    chk("idle_cen_t0", Q_t0, ONES);
    do_rd(AW'(5));
    chk("a5_reread_qt", Q_t0, DW'(8));

    for (int k = 0; k < 500; k++) begin
      A       = AW'($urandom_range(0, DEPTH - 1));
      A_t0    = ($urandom_range(0, 7) == 0) ? AW'($urandom) : '0;
      CEN_t0  = ($urandom_range(0, 9) == 0);
      GWEN_t0 = ($urandom_range(0, 9) == 0);
      WEN_t0  = ($urandom_range(0, 3) == 0) ? (rnd_word() & rnd_word() & rnd_word()) : '0;
      D_t0    = ($urandom_range(0, 1) == 0) ? (rnd_word() & rnd_word()) : '0;
      D       = rnd_word();
      WEN     = ($urandom_range(0, 2) == 0) ? '0 : rnd_word();
      case ($urandom_range(0, 3))
        0:       begin CEN = 1'b1; GWEN = $urandom_range(0, 1) == 1; end
        1:       begin CEN = 1'b0; GWEN = 1'b0; end
        default: begin CEN = 1'b0; GWEN = 1'b1; end
      endcase
      cyc();
    end
    clear_taint();

    // Reset mid-fill restarts the full fill; writes to row 0 meanwhile must be ignored.
    RST = 1'b1;
    do_idle();
    RST = 1'b0;
    for (int k = 0; k < 30; k++) do_wr('0, ONES, '0);
    RST = 1'b1;
    do_wr('0, ONES, '0);
    RST = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 200) begin
      D_t0 = ONES;
      do_wr('0, ONES, '0);
      n++;
    end
    clear_taint();
    chk("reinit_cycles", DW'(n), DW'(64));
    do_rd('0);
    chk("row0_q", Q, '0);
    chk("row0_qt", Q_t0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
